// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding constants, used by the instruction encoder/loader and the
// control unit so both sides agree on opcodes and field placement.
//   op_e          : symbolic operation codes carried on the 3-bit in_op bus
//   OPC_*         : 11-bit R/D opcodes, 8-bit CBZ opcode, 6-bit B opcode
//   *_MSB / *_LSB : bit positions of each instruction field
//   opcode11()    : maps an R/D operation to its 11-bit opcode
//   fits_signed() : checks that a 26-bit immediate sign-fits a narrower field
package legv8_pkg;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpSub  = 3'd1,
        OpAnd  = 3'd2,
        OpOrr  = 3'd3,
        OpLdur = 3'd4,
        OpStur = 3'd5,
        OpCbz  = 3'd6,
        OpB    = 3'd7
    } op_e;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [5:0]  OPC_B    = 6'b000101;

    // R and D formats
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 21;
    localparam int RM_MSB    = 20;
    localparam int RM_LSB    = 16;
    localparam int D_IMM_MSB = 20;
    localparam int D_IMM_LSB = 12;
    localparam int RN_MSB    = 9;
    localparam int RN_LSB    = 5;
    localparam int RD_MSB    = 4;
    localparam int RD_LSB    = 0;
    // CB format
    localparam int CB_OPC_MSB = 31;
    localparam int CB_OPC_LSB = 24;
    localparam int CB_IMM_MSB = 23;
    localparam int CB_IMM_LSB = 5;
    // B format
    localparam int B_OPC_MSB = 31;
    localparam int B_OPC_LSB = 26;
    localparam int B_IMM_MSB = 25;
    localparam int B_IMM_LSB = 0;

    localparam int unsigned D_IMM_W  = 9;
    localparam int unsigned CB_IMM_W = 19;

    function automatic logic [10:0] opcode11(op_e op);
        case (op)
            OpSub:   return OPC_SUB;
            OpAnd:   return OPC_AND;
            OpOrr:   return OPC_ORR;
            OpLdur:  return OPC_LDUR;
            OpStur:  return OPC_STUR;
            default: return OPC_ADD;
        endcase
    endfunction

    // True when every bit above the field's sign bit matches it.
    function automatic logic fits_signed(logic [25:0] imm, int unsigned width);
        logic [25:0] mask;
        mask = {26{1'b1}} << (width - 1);
        return ((imm & mask) == '0) || ((imm & mask) == mask);
    endfunction

endpackage

// File: rtl/legv8_word_pack.sv
// Combinational LEGv8 word packer with immediate range check.
//   op       in  3   operation code (legv8_pkg::op_e)
//   rd       in  5   Rd (R) / Rt (D, CB)
//   rn       in  5   Rn (R, D)
//   rm       in  5   Rm (R)
//   imm      in  26  signed immediate (D address, CB offset, B offset)
//   word     out 32  packed instruction
//   range_ok out 1   immediate sign-fits the field of the selected format
module legv8_word_pack
    import legv8_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        range_ok
);

    op_e op_kind;
    assign op_kind = op_e'(op);

    always_comb begin
        word     = '0;
        range_ok = 1'b1;
        unique case (op_kind)
            OpAdd, OpSub, OpAnd, OpOrr: begin
                word[OPC_MSB:OPC_LSB] = opcode11(op_kind);
                word[RM_MSB:RM_LSB]   = rm;
                word[RN_MSB:RN_LSB]   = rn;
                word[RD_MSB:RD_LSB]   = rd;
            end
            OpLdur, OpStur: begin
                word[OPC_MSB:OPC_LSB]     = opcode11(op_kind);
                word[D_IMM_MSB:D_IMM_LSB] = imm[D_IMM_W-1:0];
                word[RN_MSB:RN_LSB]       = rn;
                word[RD_MSB:RD_LSB]       = rd;
                range_ok                  = fits_signed(imm, D_IMM_W);
            end
            OpCbz: begin
                word[CB_OPC_MSB:CB_OPC_LSB] = OPC_CBZ;
                word[CB_IMM_MSB:CB_IMM_LSB] = imm[CB_IMM_W-1:0];
                word[RD_MSB:RD_LSB]         = rd;
                range_ok                    = fits_signed(imm, CB_IMM_W);
            end
            OpB: begin
                word[B_OPC_MSB:B_OPC_LSB] = OPC_B;
                word[B_IMM_MSB:B_IMM_LSB] = imm;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic LEGv8 instructions from a valid/ready stream and writes them
// sequentially into instruction memory, one registered pipeline stage deep.
//   clk, reset            clock, synchronous active-high reset
//   start                 begin a load session (only honoured when idle)
//   in_valid / in_ready   beat handshake
//   in_op .. in_imm       symbolic instruction fields
//   in_last               final beat of the program
//   mem_we/addr/wdata     instruction memory write port
//   count                 words written this session
//   busy, done            session status, one-cycle completion pulse
//   err_range, err_full   sticky: immediate out of range / memory exhausted
module instr_encoder_loader
    import legv8_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rn,
    input  logic [4:0]            in_rm,
    input  logic [25:0]           in_imm,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  err_range,
    output logic                  err_full
);

    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   LAST_SLOT = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [1:0] {StIdle, StLoad, StFinish} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  we_q;
    logic [31:0]           wdata_q;
    logic                  done_q;
    logic                  err_range_q;
    logic                  err_full_q;

    logic [31:0]           packed_word;
    logic                  range_ok;
    logic                  accept;
    logic [ADDR_WIDTH:0]   committed;
    logic                  fills_memory;

    legv8_word_pack u_pack (
        .op       (in_op),
        .rd       (in_rd),
        .rn       (in_rn),
        .rm       (in_rm),
        .imm      (in_imm),
        .word     (packed_word),
        .range_ok (range_ok)
    );

    assign accept = in_valid && (state_q == StLoad);
    // Words already written plus the one sitting in the pipeline register.
    assign committed    = count_q + {{ADDR_WIDTH{1'b0}}, we_q};
    assign fills_memory = (committed == LAST_SLOT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= BASE;
            count_q     <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            err_range_q <= 1'b0;
            err_full_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            // The pending word is written this cycle; advance past it.
            if (we_q) begin
                ptr_q   <= ptr_q + 1'b1;
                count_q <= count_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StLoad;
                        ptr_q       <= BASE;
                        count_q     <= '0;
                        err_range_q <= 1'b0;
                        err_full_q  <= 1'b0;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        if (range_ok) begin
                            we_q    <= 1'b1;
                            wdata_q <= packed_word;
                        end else begin
                            err_range_q <= 1'b1;
                        end
                        if (in_last) begin
                            state_q <= StFinish;
                        end else if (range_ok && fills_memory) begin
                            state_q    <= StFinish;
                            err_full_q <= 1'b1;
                        end
                    end
                end
                StFinish: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StLoad);
    assign busy      = (state_q != StIdle);
    // A word pending when reset arrives is suppressed in that same cycle.
    assign mem_we    = we_q & ~reset;
    assign mem_addr  = ptr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign done      = done_q;
    assign err_range = err_range_q;
    assign err_full  = err_full_q;

endmodule
